// File: rtl/softmax_row_scheduler_if.sv
// -----------------------------------------------------------------------------
// softmax_row_scheduler_if
// Bundles the signals between the softmax row scheduler and its surroundings:
// the command interface (start/num_rows/busy/done), the BRAM row reader
// (rd_start/rd_done/row_idx/row_base) and the softmax core
// (sm_valid/sm_ready/sm_done/rows_done).
//   modport master : the environment (command source, row reader, softmax core)
//   modport slave  : the scheduler itself
// -----------------------------------------------------------------------------
interface softmax_row_scheduler_if #(
  parameter int N        = 32,
  parameter int MAX_ROWS = 32
);
  localparam int ROW_W  = $clog2(MAX_ROWS);
  localparam int BASE_W = ROW_W + $clog2(N);

  logic              start;
  logic [ROW_W:0]    num_rows;
  logic              busy;
  logic              done;
  logic              rd_start;
  logic              rd_done;
  logic [ROW_W-1:0]  row_idx;
  logic [BASE_W-1:0] row_base;
  logic              sm_valid;
  logic              sm_ready;
  logic              sm_done;
  logic [ROW_W:0]    rows_done;

  modport master (
    output start, num_rows, rd_done, sm_ready, sm_done,
    input  busy, done, rd_start, row_idx, row_base, sm_valid, rows_done
  );

  modport slave (
    input  start, num_rows, rd_done, sm_ready, sm_done,
    output busy, done, rd_start, row_idx, row_base, sm_valid, rows_done
  );
endinterface

// File: rtl/softmax_row_scheduler.sv
// -----------------------------------------------------------------------------
// softmax_row_scheduler
// Sequences a multi-row softmax pass: for every row it pulses the row reader,
// presents the row base address, offers the gathered row to the softmax core
// over valid/ready, and counts the core's per-row completions.
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset (aborts a pass with no done pulse)
//   bus  - softmax_row_scheduler_if.slave: start/num_rows in, busy/done out,
//          rd_start/row_idx/row_base out, rd_done in, sm_valid/rows_done out,
//          sm_ready/sm_done in
// Configuration macro: SOFTMAX_SCHED_PREFETCH_EN
//   defined   - the next row read is issued right after a handshake, overlapping
//               softmax compute of the row just handed off
//   undefined - strictly serial; a row is read only after the previous sm_done
// All outputs are registered and derived from the next state.
// -----------------------------------------------------------------------------
module softmax_row_scheduler #(
  parameter int N        = 32,
  parameter int MAX_ROWS = 32
) (
  input logic                     clk,
  input logic                     rst,
  softmax_row_scheduler_if.slave  bus
);
  localparam int ROW_W  = $clog2(MAX_ROWS);
  localparam int BASE_W = ROW_W + $clog2(N);

  localparam logic [ROW_W:0]    MAX_ROWS_C = (ROW_W+1)'(MAX_ROWS);
  localparam logic [ROW_W:0]    ONE_CNT    = (ROW_W+1)'(1);
  localparam logic [ROW_W-1:0]  ONE_IDX    = ROW_W'(1);
  localparam logic [BASE_W-1:0] N_C        = BASE_W'(N);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_OFFER   = 3'd3,
    ST_WAIT_SM = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [ROW_W:0]    n_lat_r;
  logic [ROW_W:0]    n_lat_s;
  logic [ROW_W-1:0]  row_idx_r;
  logic [ROW_W-1:0]  row_idx_s;
  logic [BASE_W-1:0] row_base_r;
  logic [ROW_W:0]    rows_done_r;
  logic [ROW_W:0]    rows_done_s;
  logic              busy_r;
  logic              done_r;
  logic              rd_start_r;
  logic              sm_valid_r;
  logic              accept_s;
  logic              handshake_s;
  logic              last_row_s;
  logic              sm_done_cnt_s;

  // Pass bookkeeping: start acceptance, row-count clamp, row index and completion count.
  always_comb begin
    accept_s      = (state_r == ST_IDLE) && bus.start;
    handshake_s   = (state_r == ST_OFFER) && bus.sm_ready;
    // The row being offered is the last one of the pass.
    last_row_s    = (({1'b0, row_idx_r}) + ONE_CNT) >= n_lat_r;
    // Completions count everywhere but IDLE and never beyond the pass length.
    sm_done_cnt_s = bus.sm_done && (state_r != ST_IDLE) && (rows_done_r != n_lat_r);

    if (bus.num_rows > MAX_ROWS_C) begin
      n_lat_s = MAX_ROWS_C;
    end else begin
      n_lat_s = bus.num_rows;
    end

    if (accept_s) begin
      rows_done_s = '0;
    end else if (sm_done_cnt_s) begin
      rows_done_s = rows_done_r + ONE_CNT;
    end else begin
      rows_done_s = rows_done_r;
    end

    // row_idx holds at the last row so row_base stays inside the pass.
    if (accept_s) begin
      row_idx_s = '0;
    end else if (handshake_s && !last_row_s) begin
      row_idx_s = row_idx_r + ONE_IDX;
    end else begin
      row_idx_s = row_idx_r;
    end
  end

  // Next-state logic of the row sequencing FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.num_rows != '0) begin
            state_s = ST_ISSUE;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (bus.rd_done) begin
          state_s = ST_OFFER;
        end else begin
          state_s = ST_WAIT_RD;
        end
      end
      ST_OFFER: begin
        if (bus.sm_ready) begin
`ifdef SOFTMAX_SCHED_PREFETCH_EN
          // Overlap the next read with compute of the row just handed off.
          if (!last_row_s) begin
            state_s = ST_ISSUE;
          end else begin
            state_s = ST_WAIT_SM;
          end
`else
          state_s = ST_WAIT_SM;
`endif
        end else begin
          state_s = ST_OFFER;
        end
      end
      ST_WAIT_SM: begin
        if (rows_done_r == n_lat_r) begin
          state_s = ST_DONE;
`ifdef SOFTMAX_SCHED_PREFETCH_EN
        end else begin
          // Every row is already handed off; just wait for the count.
          state_s = ST_WAIT_SM;
        end
`else
        end else if (bus.sm_done && ((rows_done_r + ONE_CNT) < n_lat_r)) begin
          // Non-final row finished: read the next one.
          state_s = ST_ISSUE;
        end else begin
          // The final completion is picked up by the count next cycle.
          state_s = ST_WAIT_SM;
        end
`endif
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, pass registers and registered outputs (outputs follow the next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      n_lat_r     <= '0;
      row_idx_r   <= '0;
      row_base_r  <= '0;
      rows_done_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_start_r  <= 1'b0;
      sm_valid_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      if (accept_s) begin
        n_lat_r <= n_lat_s;
      end
      row_idx_r   <= row_idx_s;
      row_base_r  <= BASE_W'(row_idx_s) * N_C;
      rows_done_r <= rows_done_s;
      busy_r      <= (state_s != ST_IDLE);
      done_r      <= (state_s == ST_DONE);
      rd_start_r  <= (state_s == ST_ISSUE);
      sm_valid_r  <= (state_s == ST_OFFER);
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.rd_start  = rd_start_r;
  assign bus.row_idx   = row_idx_r;
  assign bus.row_base  = row_base_r;
  assign bus.sm_valid  = sm_valid_r;
  assign bus.rows_done = rows_done_r;
endmodule
